// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Round-robin, lockable write/read arbiter for a shared SDP BRAM.
// Revision : 1.0
// ============================================================================
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR-1:0]            wr_lock,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]            wr_gnt,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD-1:0]            rd_lock,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_gnt,
  output logic                         rd_rvalid,
  output logic [NUM_RD-1:0]            rd_rid,
  output logic [DATA_WIDTH-1:0]        rd_rdata,
  output logic                         bram_we_a,
  output logic [ADDR_WIDTH-1:0]        bram_addr_a,
  output logic [DATA_WIDTH-1:0]        bram_din_a,
  output logic [ADDR_WIDTH-1:0]        bram_addr_b,
  input  logic [DATA_WIDTH-1:0]        bram_dout_b
);

  localparam int c_WR_IW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int c_RD_IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  function automatic int f_wrap(input int v, input int n);
    f_wrap = (v >= n) ? v - n : v;
  endfunction

  logic [ADDR_WIDTH-1:0] w_wr_addr_arr [NUM_WR];
  logic [DATA_WIDTH-1:0] w_wr_data_arr [NUM_WR];
  logic [ADDR_WIDTH-1:0] w_rd_addr_arr [NUM_RD];

  for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_unpack
    assign w_wr_addr_arr[g] = wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wr_data_arr[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_unpack
    assign w_rd_addr_arr[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [c_WR_IW-1:0]    r_wr_ptr, r_wr_owner, w_wr_sel, w_wr_idx;
  logic [c_RD_IW-1:0]    r_rd_ptr, r_rd_owner, w_rd_sel, w_rd_idx;
  logic                  r_wr_locked, r_rd_locked;
  logic                  w_wr_hit, w_rd_hit, w_wr_go, w_rd_go, w_collide;
  logic                  r_rd_rvalid;
  logic [NUM_RD-1:0]     r_rd_rid;
  logic [ADDR_WIDTH-1:0] r_rd_addr_last;

  // Descending scan so the nearest requester at or after the pointer wins.
  always_comb begin
    w_wr_hit = 1'b0;
    w_wr_sel = '0;
    w_wr_idx = '0;
    if (r_wr_locked) begin
      w_wr_sel = r_wr_owner;
      w_wr_hit = wr_req[r_wr_owner];
    end else begin
      for (int k = NUM_WR - 1; k >= 0; k--) begin
        w_wr_idx = c_WR_IW'(f_wrap(int'(r_wr_ptr) + k, NUM_WR));
        if (wr_req[w_wr_idx]) begin
          w_wr_sel = w_wr_idx;
          w_wr_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_sel = '0;
    w_rd_idx = '0;
    if (r_rd_locked) begin
      w_rd_sel = r_rd_owner;
      w_rd_hit = rd_req[r_rd_owner];
    end else begin
      for (int k = NUM_RD - 1; k >= 0; k--) begin
        w_rd_idx = c_RD_IW'(f_wrap(int'(r_rd_ptr) + k, NUM_RD));
        if (rd_req[w_rd_idx]) begin
          w_rd_sel = w_rd_idx;
          w_rd_hit = 1'b1;
        end
      end
    end
  end

  // A read of the address being written this cycle waits one cycle.
  assign w_wr_go   = rst_n && w_wr_hit;
  assign w_collide = w_wr_go && (w_rd_addr_arr[w_rd_sel] == w_wr_addr_arr[w_wr_sel]);
  assign w_rd_go   = rst_n && w_rd_hit && !w_collide;

  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (w_wr_go) wr_gnt[w_wr_sel] = 1'b1;
    if (w_rd_go) rd_gnt[w_rd_sel] = 1'b1;
  end

  assign bram_we_a   = w_wr_go;
  assign bram_addr_a = w_wr_addr_arr[w_wr_sel];
  assign bram_din_a  = w_wr_data_arr[w_wr_sel];
  assign bram_addr_b = w_rd_go ? w_rd_addr_arr[w_rd_sel] : r_rd_addr_last;
  assign rd_rvalid   = r_rd_rvalid;
  assign rd_rid      = r_rd_rid;
  assign rd_rdata    = bram_dout_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_wr_owner     <= '0;
      r_wr_locked    <= 1'b0;
      r_rd_ptr       <= '0;
      r_rd_owner     <= '0;
      r_rd_locked    <= 1'b0;
      r_rd_rvalid    <= 1'b0;
      r_rd_rid       <= '0;
      r_rd_addr_last <= '0;
    end else begin
      if (w_wr_go) begin
        r_wr_ptr    <= c_WR_IW'(f_wrap(int'(w_wr_sel) + 1, NUM_WR));
        r_wr_locked <= wr_lock[w_wr_sel];
        r_wr_owner  <= w_wr_sel;
      end
      if (w_rd_go) begin
        r_rd_ptr       <= c_RD_IW'(f_wrap(int'(w_rd_sel) + 1, NUM_RD));
        r_rd_locked    <= rd_lock[w_rd_sel];
        r_rd_owner     <= w_rd_sel;
        r_rd_addr_last <= w_rd_addr_arr[w_rd_sel];
      end
      r_rd_rvalid <= w_rd_go;
      r_rd_rid    <= rd_gnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Purpose  : Scoreboard bench for bram_port_arbiter with a behavioural BRAM.
// Revision : 1.0
// ============================================================================
module tb_bram_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 256;
  localparam int NW = 2;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NW-1:0]    wr_req = '0, wr_lock = '0, wr_gnt;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NR-1:0]    rd_req = '0, rd_lock = '0, rd_gnt, rd_rid;
  logic [NR*AW-1:0] rd_addr = '0;
  logic             rd_rvalid, bram_we_a;
  logic [DW-1:0]    rd_rdata, bram_din_a, bram_dout_b;
  logic [AW-1:0]    bram_addr_a, bram_addr_b;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_lock(rd_lock), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rid(rd_rid), .rd_rdata(rd_rdata),
    .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a),
    .bram_addr_b(bram_addr_b), .bram_dout_b(bram_dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural simple dual-port BRAM with a registered read port.
  logic [DW-1:0] bmem [64];
  always @(posedge clk) begin
    if (bram_we_a) bmem[bram_addr_a[5:0]] <= bram_din_a;
    bram_dout_b <= bmem[bram_addr_b[5:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [NW-1:0] wg;
    logic [NR-1:0] rg;
    logic [AW-1:0] aa;
    logic [DW-1:0] din;
    logic [AW-1:0] ab;
    bit            chk_b;
  } gnt_t;
  typedef struct {
    int            cyc;
    logic [NR-1:0] rid;
    logic [DW-1:0] data;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  // Stimulus views and reference-model state
  logic [AW-1:0] s_waddr [NW];
  logic [DW-1:0] s_wdata [NW];
  logic [AW-1:0] s_raddr [NR];
  logic [DW-1:0] refmem  [64];
  int  m_wptr = 0, m_rptr = 0, m_wown = 0, m_rown = 0;
  bit  m_wlk = 0, m_rlk = 0, m_bvalid = 0;
  logic [AW-1:0] m_blast = '0;

  function automatic bit bt(input logic [7:0] v, input int i);
    return v[i[2:0]];
  endfunction

  // Locked owner keeps the port (or idles); otherwise first requester from ptr onward.
  function automatic int pick(input logic [7:0] req, input int n, input int ptr,
                              input bit lk, input int own);
    if (lk) return bt(req, own) ? own : -1;
    for (int k = 0; k < n; k++)
      if (bt(req, (ptr + k) % n)) return (ptr + k) % n;
    return -1;
  endfunction

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  task automatic step();
    gnt_t g;
    rd_t  r;
    int   wg, rg;
    for (int i = 0; i < NW; i++) begin
      wr_addr[i*AW +: AW] = s_waddr[i];
      wr_data[i*DW +: DW] = s_wdata[i];
    end
    for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = s_raddr[i];
    g.cyc = cyc; g.wg = '0; g.rg = '0; g.aa = '0; g.din = '0; g.ab = '0; g.chk_b = 0;
    if (!rst_n) begin
      m_wptr = 0; m_rptr = 0; m_wlk = 0; m_rlk = 0; m_bvalid = 0;
    end else begin
      wg = pick({6'b0, wr_req}, NW, m_wptr, m_wlk, m_wown);
      rg = pick({4'b0, rd_req}, NR, m_rptr, m_rlk, m_rown);
      if (wg >= 0 && rg >= 0 && s_raddr[rg] == s_waddr[wg]) rg = -1;
      if (wg >= 0) begin
        g.wg = NW'(1) << wg; g.aa = s_waddr[wg]; g.din = s_wdata[wg];
        m_wptr = (wg + 1) % NW; m_wlk = bt({6'b0, wr_lock}, wg); m_wown = wg;
      end
      if (rg >= 0) begin
        g.rg = NR'(1) << rg; g.ab = s_raddr[rg]; g.chk_b = 1;
        m_rptr = (rg + 1) % NR; m_rlk = bt({4'b0, rd_lock}, rg); m_rown = rg;
        m_blast = s_raddr[rg]; m_bvalid = 1;
        r.cyc = cyc + 1; r.rid = g.rg; r.data = refmem[s_raddr[rg][5:0]];
        rq.push_back(r);
      end else if (m_bvalid) begin
        g.ab = m_blast; g.chk_b = 1;
      end
      if (wg >= 0) refmem[s_waddr[wg][5:0]] = s_wdata[wg];
    end
    gq.push_back(g);
    @(posedge clk); #1;
  endtask

  gnt_t mg;
  rd_t  mr;
  bit   exp_v;
  always @(negedge clk) begin
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      mg = gq.pop_front();
      chk("wr_gnt", DW'(wr_gnt), DW'(mg.wg));
      chk("rd_gnt", DW'(rd_gnt), DW'(mg.rg));
      chk("bram_we_a", DW'(bram_we_a), DW'(|mg.wg));
      if (|mg.wg) begin
        chk("bram_addr_a", DW'(bram_addr_a), DW'(mg.aa));
        chk("bram_din_a", bram_din_a, mg.din);
      end
      if (mg.chk_b) chk("bram_addr_b", DW'(bram_addr_b), DW'(mg.ab));
    end
    if (mon_en) begin
      exp_v = (rq.size() > 0 && rq[0].cyc == cyc);
      chk("rd_rvalid", DW'(rd_rvalid), DW'(exp_v));
      if (exp_v) begin
        mr = rq.pop_front();
        chk("rd_rid", DW'(rd_rid), DW'(mr.rid));
        chk("rd_rdata", rd_rdata, mr.data);
      end else begin
        chk("rd_rid_idle", DW'(rd_rid), '0);
      end
    end
  end

  task automatic idle_all();
    wr_req = '0; wr_lock = '0; rd_req = '0; rd_lock = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      bmem[i] = '0;
      refmem[i] = '0;
    end
    for (int i = 0; i < NW; i++) begin s_waddr[i] = '0; s_wdata[i] = '0; end
    for (int i = 0; i < NR; i++) s_raddr[i] = '0;
    @(posedge clk); #1;

    // Reset with every request asserted
    rst_n = 1'b0; wr_req = '1; rd_req = '1;
    step(); mon_en = 1; step(); step();
    rst_n = 1'b1; idle_all();

    // Preload 0x0005 and round-robin writes
    s_waddr[0] = 15'h0005; s_wdata[0] = {32{8'hA5}}; wr_req = 2'b01; step();
    s_waddr[0] = 15'h0020; s_waddr[1] = 15'h0021; wr_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      s_wdata[0] = {8{$urandom()}}; s_wdata[1] = {8{$urandom()}}; step();
    end
    idle_all();

    // Single read latency check
    s_raddr[2] = 15'h0005; rd_req = 4'b0100; step();
    rd_req = '0; step();

    // Locked read burst by client 0 against client 1
    s_raddr[0] = 15'h0001; s_raddr[1] = 15'h0002; rd_req = 4'b0011;
    rd_lock = 4'b0001; step(); step();
    rd_lock = 4'b0000; step(); step(); step();
    idle_all(); step();

    // Same-address write/read collision
    s_waddr[0] = 15'h0010; s_wdata[0] = {8{$urandom()}}; wr_req = 2'b01;
    s_raddr[0] = 15'h0010; rd_req = 4'b0001; step();
    wr_req = '0; step();
    idle_all(); step();

    // Reset during a write lock with a read in flight
    wr_req = 2'b01; wr_lock = 2'b01; step();
    s_raddr[1] = 15'h0003; rd_req = 4'b0010; step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; wr_lock = '0; rd_lock = '0; wr_req = 2'b11; rd_req = 4'b1111;
    for (int i = 0; i < NR; i++) s_raddr[i] = AW'(40 + i);
    step(); step();
    idle_all();

    // Randomized traffic over a small address window to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(99) != 0);
      wr_req  = NW'($urandom());
      rd_req  = NR'($urandom());
      for (int i = 0; i < NW; i++) begin
        wr_lock[i] = ($urandom_range(3) == 0);
        s_waddr[i] = AW'($urandom_range(15));
        s_wdata[i] = {8{$urandom()}};
      end
      for (int i = 0; i < NR; i++) begin
        rd_lock[i] = ($urandom_range(3) == 0);
        s_raddr[i] = AW'($urandom_range(15));
      end
      step();
    end
    rst_n = 1'b1; idle_all();
    step(); step(); step();
    @(negedge clk); #1;
    chk("drain", DW'(gq.size() + rq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
